// File: rtl/mux_n_pipe.sv
// N-way registered mux feeding a two-entry skid buffer with valid/ready on both sides.
// Optional sticky out-of-range select flag enabled by `define MUX_N_PIPE_SEL_CHECK_EN.
module mux_n_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    localparam int unsigned SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        seletor,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] item;
    logic [31:0]      sel_idx;
    logic             acc;
    logic             xfer;

    assign sel_idx   = 32'(seletor);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_ready  = in_ready_q;
    assign acc       = in_valid & in_ready_q;
    assign xfer      = out_valid & out_ready;

    // Out-of-range selects fall through to the all-zero default.
    always_comb begin
        item = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (sel_idx == k) item = in_data[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (acc) begin
                    main_d  = item;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (acc && xfer) begin
                    main_d = item;
                end else if (acc) begin
                    skid_d  = item;
                    state_d = FULL;
                end else if (xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (xfer) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Registered ready looks ahead at the next state, so out_ready never reaches in_ready combinationally.
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

`ifdef MUX_N_PIPE_SEL_CHECK_EN
    logic sel_err_q, sel_err_d;

    always_comb begin
        sel_err_d = sel_err_q | (acc & (sel_idx >= NUM_IN));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sel_err_q <= 1'b0;
        else        sel_err_q <= sel_err_d;
    end

    assign sel_err = sel_err_q;
`else
    assign sel_err = 1'b0;
`endif

endmodule
